da_fir_filter: RTL and testbench

//  Complete bit-serial distributed-arithmetic (DA) FIR filter with TAPS taps.

---
 rtl/da_fir_pkg.sv | 53 +++++
 rtl/da_fir_filter_if.sv | 16 +
 rtl/da_partition_lut.sv | 28 ++
 rtl/da_fir_filter.sv | 158 +++++++++++++++
 tb/tb_da_fir_filter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/da_fir_pkg.sv
// Shared types and elaboration-time helpers for the distributed-arithmetic FIR.
package da_fir_pkg;

    // Widest packed coefficient vector the LUT generator accepts.
    localparam int DA_MAX_COEF_BITS = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } da_state_e;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int da_clog2(input int v);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // DA LUT entry: the sum of the coefficients of taps base+j for every set bit j of addr.
    // Coefficients are sign-extended to 64 bits before summing, so the result is exact.
    function automatic logic signed [63:0] da_lut_entry(
        input logic [DA_MAX_COEF_BITS-1:0] coefs,
        input int                          base,
        input int                          addr,
        input int                          order,
        input int                          coef_w
    );
        logic signed [63:0] acc;
        logic signed [63:0] c;
        acc = 64'sd0;
        for (int j = 0; j < order; j++) begin
            if (addr[j]) begin
                c = 64'sd0;
                for (int b = 0; b < 64; b++) begin
                    if (b < coef_w) begin
                        c[b] = coefs[(base + j) * coef_w + b];
                    end else begin
                        c[b] = coefs[(base + j) * coef_w + coef_w - 1];
                    end
                end
                acc = acc + c;
            end else begin
                acc = acc + 64'sd0;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/da_fir_filter_if.sv
// Sample-in / result-out stream bundle of the DA FIR filter.
interface da_fir_filter_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ACC_W      = 36
);
    logic                  x_valid;
    logic                  x_ready;
    logic [WORD_WIDTH-1:0] x;
    logic                  y_valid;
    logic [ACC_W-1:0]      y;

    // Sample source and result sink side.
    modport master (output x_valid, output x, input x_ready, input y_valid, input y);
    // Filter side.
    modport slave  (input x_valid, input x, output x_ready, output y_valid, output y);
endinterface

// File: rtl/da_partition_lut.sv
// Constant DA lookup table for one partition of PART_ORDER taps.
// Entry a holds the sum of the coefficients selected by the set bits of a.
module da_partition_lut
    import da_fir_pkg::*;
#(
    parameter int                              PART_ORDER = 3,
    parameter int                              COEF_WIDTH = 16,
    parameter logic [PART_ORDER*COEF_WIDTH-1:0] PART_COEFS = '0
) (
    input  logic        [PART_ORDER-1:0]            addr,
    output logic signed [COEF_WIDTH+PART_ORDER-1:0] data
);
    localparam int LUT_W   = COEF_WIDTH + PART_ORDER;
    localparam int ENTRIES = 2 ** PART_ORDER;

    logic signed [LUT_W-1:0] lut_s [ENTRIES];

    for (genvar a = 0; a < ENTRIES; a++) begin : g_entry
        localparam logic signed [63:0] ENTRY =
            da_lut_entry(DA_MAX_COEF_BITS'(PART_COEFS), 0, a, PART_ORDER, COEF_WIDTH);
        assign lut_s[a] = ENTRY[LUT_W-1:0];
    end

    // Table read, addressed by one bit-slice of the partition's taps.
    always_comb begin
        data = lut_s[addr];
    end
endmodule

// File: rtl/da_fir_filter.sv
// Bit-serial distributed-arithmetic FIR filter.
// One sample is accepted in IDLE, WORD_WIDTH bit-slices are accumulated MSB first
// (the sign slice is subtracted), and the result is published in DONE.
module da_fir_filter
    import da_fir_pkg::*;
#(
    parameter int                        WORD_WIDTH = 16,
    parameter int                        COEF_WIDTH = 16,
    parameter int                        TAPS       = 6,
    parameter int                        PART_ORDER = 3,
    parameter logic [TAPS*COEF_WIDTH-1:0] COEFS     = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    da_fir_filter_if.slave bus
);
    localparam int NUM_PARTS = TAPS / PART_ORDER;
    localparam int LUT_W     = COEF_WIDTH + PART_ORDER;
    localparam int SUM_W     = COEF_WIDTH + PART_ORDER + da_clog2(NUM_PARTS);
    localparam int ACC_W     = SUM_W + WORD_WIDTH;
    localparam int CNT_W     = (WORD_WIDTH > 1) ? da_clog2(WORD_WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_WIDTH - 1);
    localparam logic [1:0]       ST_IDLE    = IDLE;
    localparam logic [1:0]       ST_COMPUTE = COMPUTE;
    localparam logic [1:0]       ST_DONE    = DONE;

    logic [WORD_WIDTH-1:0]   taps_q [TAPS];
    logic [WORD_WIDTH-1:0]   taps_d [TAPS];
    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        bit_q, bit_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0]        y_q, y_d;
    logic                    y_valid_q, y_valid_d;

    logic signed [LUT_W-1:0] part_s [NUM_PARTS];
    logic signed [SUM_W-1:0] sum_s;
    logic signed [ACC_W-1:0] step_s;

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
        logic [PART_ORDER-1:0] addr_s;
        for (genvar j = 0; j < PART_ORDER; j++) begin : g_addr
            assign addr_s[j] = taps_q[p*PART_ORDER + j][bit_q];
        end
        da_partition_lut #(
            .PART_ORDER (PART_ORDER),
            .COEF_WIDTH (COEF_WIDTH),
            .PART_COEFS (COEFS[p*PART_ORDER*COEF_WIDTH +: PART_ORDER*COEF_WIDTH])
        ) u_lut (
            .addr (addr_s),
            .data (part_s[p])
        );
    end

    // Adder tree: sign-extend every partition output and sum them.
    always_comb begin
        sum_s = '0;
        for (int p = 0; p < NUM_PARTS; p++) begin
            sum_s = sum_s + SUM_W'(part_s[p]);
        end
    end

    // Shift-accumulate step; the first (sign) slice carries negative weight.
    always_comb begin
        if (bit_q == LAST_BIT) begin
            step_s = -ACC_W'(sum_s);
        end else begin
            step_s = (acc_q <<< 1) + ACC_W'(sum_s);
        end
    end

    // Next-state logic: enable freezes everything, clear wins over a handshake.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        taps_d    = taps_q;
        if (!en) begin
            state_d = state_q;
        end else if (clr) begin
            state_d   = ST_IDLE;
            bit_d     = '0;
            acc_d     = '0;
            y_d       = '0;
            y_valid_d = 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                taps_d[k] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    y_valid_d = 1'b0;
                    if (bus.x_valid) begin
                        taps_d[0] = bus.x;
                        for (int k = 1; k < TAPS; k++) begin
                            taps_d[k] = taps_q[k-1];
                        end
                        acc_d   = '0;
                        bit_d   = LAST_BIT;
                        state_d = ST_COMPUTE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COMPUTE: begin
                    acc_d = step_s;
                    if (bit_q == '0) begin
                        y_d       = step_s;
                        y_valid_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        bit_d = bit_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    y_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    y_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // State, tap, accumulator and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= taps_d[k];
            end
        end
    end

    // The pulse stays pending in DONE while en is low and shows once en returns.
    assign bus.x_ready = (state_q == ST_IDLE);
    assign bus.y_valid = y_valid_q & en;
    assign bus.y       = y_q;
endmodule

// File: tb/tb_da_fir_filter.sv
// Directed and random checks of da_fir_filter against a plain convolution model.
module tb_da_fir_filter;
    localparam int WW    = 16;
    localparam int CW    = 16;
    localparam int TAPS  = 4;
    localparam int PO    = 2;
    localparam int ACC_W = CW + PO + 1 + WW;
    localparam int LAT   = WW + 1;
    localparam logic [TAPS*CW-1:0] COEFS = {16'sd4, 16'sd3, 16'sd2, 16'sd1};

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr;

    da_fir_filter_if #(.WORD_WIDTH(WW), .ACC_W(ACC_W)) bus ();

    da_fir_filter #(
        .WORD_WIDTH (WW),
        .COEF_WIDTH (CW),
        .TAPS       (TAPS),
        .PART_ORDER (PO),
        .COEFS      (COEFS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint h [TAPS] = '{64'sd1, 64'sd2, 64'sd3, 64'sd4};
    longint hist [$];
    longint last_y;

    // Convolution over the newest TAPS samples; returns the expected output.
    function automatic longint model_push(input logic [WW-1:0] v);
        longint s;
        hist.push_front(longint'($signed(v)));
        if (hist.size() > TAPS) void'(hist.pop_back());
        s = 0;
        for (int k = 0; k < hist.size(); k++) s += h[k] * hist[k];
        return s;
    endfunction

    function automatic longint ysig();
        return longint'($signed(bus.y));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present v, return at the negedge right after the accepting edge.
    task automatic accept(input logic [WW-1:0] v, output longint exp);
        int guard;
        guard = 0;
        bus.x_valid = 1'b1;
        bus.x       = v;
        while (bus.x_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.x_valid = 1'b0;
        exp = model_push(v);
    endtask

    task automatic wait_y(inout int lat);
        while (bus.y_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send(input logic [WW-1:0] v, input string tag);
        longint exp;
        int     lat;
        accept(v, exp);
        lat = 1;
        wait_y(lat);
        last_y = ysig();
        check({tag, "_y"}, last_y, exp);
        check({tag, "_lat"}, lat, LAT);
        @(negedge clk);
        check({tag, "_pulse"}, bus.y_valid, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        hist.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Counts y_valid pulses over a window; used after an abort.
    task automatic expect_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            if (bus.y_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        check({tag, "_pulses"}, pulses, 0);
        check({tag, "_y"}, ysig(), 0);
        check({tag, "_ready"}, bus.x_ready, 1);
    endtask

    initial begin
        longint e;
        longint expq [$];
        int     acc_cyc [$];
        int     lat;

        rst = 1'b0; en = 1'b1; clr = 1'b0;
        bus.x_valid = 1'b0; bus.x = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_y", ysig(), 0);
        check("rst_yvalid", bus.y_valid, 0);
        check("rst_ready", bus.x_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // Impulse response
        send(16'd1, "imp0"); check("imp0_c", last_y, 1);
        send(16'd0, "imp1"); check("imp1_c", last_y, 2);
        send(16'd0, "imp2"); check("imp2_c", last_y, 3);
        send(16'd0, "imp3"); check("imp3_c", last_y, 4);
        send(16'd0, "imp4"); check("imp4_c", last_y, 0);

        // Sign bit handling
        reset_dut();
        send(16'hFFFF, "neg1"); check("neg1_c", last_y, -1);
        send(16'h8000, "neg2"); check("neg2_c", last_y, -32770);

        // Full scale negative
        reset_dut();
        for (int i = 0; i < 4; i++) send(16'h8000, "full");
        check("full_c", last_y, -327680);

        // Backpressure: x_valid held high for 40 cycles
        reset_dut();
        bus.x_valid = 1'b1;
        bus.x = 16'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (bus.x_ready === 1'b1) begin
                acc_cyc.push_back(c);
                expq.push_back(model_push(bus.x));
            end
            if (bus.y_valid === 1'b1 && expq.size() > 0) check("bp_y", ysig(), expq.pop_front());
            @(negedge clk);
            bus.x = 16'($urandom);
        end
        bus.x_valid = 1'b0;
        check("bp_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() >= 3) begin
            check("bp_gap1", acc_cyc[1] - acc_cyc[0], WW + 2);
            check("bp_gap2", acc_cyc[2] - acc_cyc[1], WW + 2);
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.y_valid === 1'b1 && expq.size() > 0) check("bp_y", ysig(), expq.pop_front());
            @(negedge clk);
        end
        check("bp_drained", expq.size(), 0);

        // Random samples with random idle gaps
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(16'($urandom), "rnd");
        end

        // en stall mid-COMPUTE: five frozen cycles add five cycles of latency
        accept(16'($urandom), e);
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        en = 1'b0;
        repeat (5) begin @(negedge clk); lat++; end
        en = 1'b1;
        wait_y(lat);
        check("stall_lat", lat, LAT + 5);
        check("stall_y", ysig(), e);
        @(negedge clk);

        // en low in DONE: pulse withheld, then delivered once
        accept(16'($urandom), e);
        lat = 1;
        wait_y(lat);
        en = 1'b0;
        #1;
        check("done_hold_v", bus.y_valid, 0);
        repeat (3) @(negedge clk);
        check("done_hold_v2", bus.y_valid, 0);
        check("done_hold_rdy", bus.x_ready, 0);
        en = 1'b1;
        #1;
        check("done_resume_v", bus.y_valid, 1);
        check("done_resume_y", ysig(), e);
        @(negedge clk);
        check("done_single", bus.y_valid, 0);

        // Reset abort at COMPUTE cycle 8
        send(16'd5, "pre_rst");
        accept(16'd9, e);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("abort_rst", 30);
        send(16'd1, "post_rst"); check("post_rst_c", last_y, 1);

        // Clear abort at COMPUTE cycle 8
        send(16'd5, "pre_clr");
        accept(16'd9, e);
        repeat (7) @(negedge clk);
        clr = 1'b1;
        hist.delete();
        @(negedge clk);
        clr = 1'b0;
        expect_quiet("abort_clr", 30);
        send(16'd1, "post_clr"); check("post_clr_c", last_y, 1);

        // Clear beats a simultaneous handshake
        clr = 1'b1;
        bus.x_valid = 1'b1;
        bus.x = 16'd7;
        hist.delete();
        @(negedge clk);
        clr = 1'b0;
        bus.x_valid = 1'b0;
        expect_quiet("clr_prio", 25);
        send(16'd1, "post_prio"); check("post_prio_c", last_y, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
